// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage RV64 core.
// Decides per cycle whether IF/ID/EX hold, whether EX gets a NOP bubble,
// and whether wrong-path IF/ID contents are discarded.
module hazard_ctrl #(
  parameter int unsigned STALL_CNT_W  = 16,
  parameter int unsigned MAX_MEM_WAIT = 8
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   id_use_rs2,
  input  logic                   id_is_jalr,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_wb,
  input  logic                   ex_load,
  input  logic [4:0]             mem_rd,
  input  logic                   mem_load,
  input  logic                   mem_busy,
  input  logic                   br_taken,
  output logic                   stall_if,
  output logic                   stall_id,
  output logic                   stall_ex,
  output logic                   bubble_ex,
  output logic                   flush_if,
  output logic                   flush_id,
  output logic [2:0]             state,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic                   mem_timeout
);

  localparam logic [2:0] ST_RUN       = 3'd0;
  localparam logic [2:0] ST_LOAD_USE  = 3'd1;
  localparam logic [2:0] ST_JALR_WAIT = 3'd2;
  localparam logic [2:0] ST_FLUSH     = 3'd3;
  localparam logic [2:0] ST_MEM_WAIT  = 3'd4;

  localparam logic [STALL_CNT_W-1:0] StallOne = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [8:0]             MaxWait  = 9'(MAX_MEM_WAIT);

  logic [2:0]             state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [7:0]             wait_cnt_q, wait_cnt_d;
  logic                   timeout_q, timeout_d;
  logic                   haz_lu, haz_jx, haz_jm;
  logic [8:0]             wait_nxt;

  // Hazard terms; x0 and ID bubbles never create a dependency
  always_comb begin
    haz_lu = id_valid && ex_load && (ex_rd != 5'd0) &&
             ((id_rs1 == ex_rd) || (id_use_rs2 && (id_rs2 == ex_rd)));
    haz_jx = id_valid && id_is_jalr && ex_wb && (ex_rd != 5'd0) && (id_rs1 == ex_rd);
    haz_jm = id_valid && id_is_jalr && mem_load && (mem_rd != 5'd0) && (id_rs1 == mem_rd);
  end

  // Control outputs and next state from current state and inputs
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    bubble_ex = 1'b0;
    flush_if  = 1'b0;
    flush_id  = 1'b0;
    state_d   = state_q;
    case (state_q)
      ST_RUN, ST_LOAD_USE, ST_JALR_WAIT: begin
        if (mem_busy) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
          state_d  = ST_MEM_WAIT;
        end else if (br_taken) begin
          flush_if  = 1'b1;
          flush_id  = 1'b1;
          bubble_ex = 1'b1;
          state_d   = ST_FLUSH;
        end else if (haz_lu) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
          state_d   = ST_LOAD_USE;
        end else if (haz_jx || haz_jm) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
          state_d   = ST_JALR_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // Second wrong-path instruction sits in ID this cycle
        flush_id = 1'b1;
        if (mem_busy) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
          state_d  = ST_MEM_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        // br_taken ignored: EX is frozen and holds the redirect
        if (mem_busy) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
          state_d  = ST_MEM_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Busy-run counter, sticky timeout and saturating stall statistics
  always_comb begin
    wait_nxt    = {1'b0, wait_cnt_q} + 9'd1;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    if (mem_busy) begin
      if (wait_cnt_q != 8'hff) wait_cnt_d = wait_nxt[7:0];
      if (wait_nxt >= MaxWait) timeout_d = 1'b1;
    end else begin
      wait_cnt_d = 8'd0;
    end
    if (stall_id && (stall_cnt_q != {STALL_CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + StallOne;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      wait_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign state        = state_q;
  assign stall_cycles = stall_cnt_q;
  assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: inputs driven on the falling edge,
// control outputs sampled 1 time unit later, registers sampled after the rising edge.
module tb_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        reset;
  logic        id_valid, id_use_rs2, id_is_jalr;
  logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
  logic        ex_wb, ex_load, mem_load, mem_busy, br_taken;
  logic        stall_if, stall_id, stall_ex, bubble_ex, flush_if, flush_id;
  logic [2:0]  state;
  logic [15:0] stall_cycles;
  logic        mem_timeout;

  int checks = 0;
  int errors = 0;

  // Packed view: {stall_if, stall_id, stall_ex, bubble_ex, flush_if, flush_id}
  logic [5:0] ctrl;
  assign ctrl = {stall_if, stall_id, stall_ex, bubble_ex, flush_if, flush_id};

  hazard_ctrl #(.STALL_CNT_W(16), .MAX_MEM_WAIT(8)) dut (
    .CLK(CLK), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs2(id_use_rs2), .id_is_jalr(id_is_jalr), .ex_rd(ex_rd), .ex_wb(ex_wb),
    .ex_load(ex_load), .mem_rd(mem_rd), .mem_load(mem_load), .mem_busy(mem_busy),
    .br_taken(br_taken), .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .bubble_ex(bubble_ex), .flush_if(flush_if), .flush_id(flush_id), .state(state),
    .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic set_idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs2 = 0; id_is_jalr = 0;
    ex_rd = 0; ex_wb = 0; ex_load = 0; mem_rd = 0; mem_load = 0;
    mem_busy = 0; br_taken = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    set_idle();
    reset = 0;
    @(negedge CLK);
    reset = 1;
  endtask

  // Drives ID/EX for a load-use pair: ld x5 in EX, add x?,x5 in ID
  task automatic drive_lu();
    set_idle();
    id_valid = 1; id_rs1 = 5; ex_rd = 5; ex_wb = 1; ex_load = 1;
  endtask

  task automatic test_reset();
    reset = 0;
    set_idle();
    #3;
    checks++;
    if (state !== 3'd0 || stall_cycles !== 16'd0 || mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: got state=%0d cnt=%0d to=%b, want 0 0 0",
               state, stall_cycles, mem_timeout);
    end
    checks++;
    if (ctrl !== 6'b000000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000", ctrl);
    end
    @(negedge CLK);
    reset = 1;
  endtask

  task automatic test_load_use();
    do_reset();
    drive_lu();
    #1;
    checks++;
    if (ctrl !== 6'b110100) begin
      errors++;
      $display("FAIL lu_ctrl: got %b want 110100", ctrl);
    end
    @(posedge CLK); #1;
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL lu_state: got %0d want 1", state);
    end
    // Bubble now in EX
    @(negedge CLK);
    set_idle(); id_valid = 1; id_rs1 = 5;
    #1;
    checks++;
    if (ctrl !== 6'b000000) begin
      errors++;
      $display("FAIL lu_release: got %b want 000000", ctrl);
    end
    @(posedge CLK); #1;
    checks++;
    if (state !== 3'd0 || stall_cycles !== 16'd1) begin
      errors++;
      $display("FAIL lu_after: got state=%0d cnt=%0d want 0 1", state, stall_cycles);
    end
  endtask

  task automatic test_filter();
    do_reset();
    set_idle(); id_valid = 1; ex_load = 1; ex_wb = 1; ex_rd = 0; id_rs1 = 0;
    #1;
    checks++;
    if (ctrl !== 6'b000000) begin
      errors++;
      $display("FAIL filt_x0: got %b want 000000", ctrl);
    end
    @(negedge CLK);
    set_idle(); id_valid = 0; ex_load = 1; ex_wb = 1; ex_rd = 5; id_rs1 = 5;
    #1;
    checks++;
    if (ctrl !== 6'b000000) begin
      errors++;
      $display("FAIL filt_invalid: got %b want 000000", ctrl);
    end
    @(negedge CLK);
    set_idle(); id_valid = 1; ex_load = 1; ex_rd = 5; id_rs1 = 3; id_rs2 = 5; id_use_rs2 = 0;
    #1;
    checks++;
    if (ctrl !== 6'b000000) begin
      errors++;
      $display("FAIL filt_rs2_unused: got %b want 000000", ctrl);
    end
    id_use_rs2 = 1;
    #1;
    checks++;
    if (ctrl !== 6'b110100) begin
      errors++;
      $display("FAIL filt_rs2_used: got %b want 110100", ctrl);
    end
    @(posedge CLK); #1;
    checks++;
    if (state !== 3'd1 || stall_cycles !== 16'd1) begin
      errors++;
      $display("FAIL filt_state: got state=%0d cnt=%0d want 1 1", state, stall_cycles);
    end
  endtask

  task automatic test_jalr();
    do_reset();
    set_idle(); id_valid = 1; id_is_jalr = 1; id_rs1 = 7; ex_load = 1; ex_wb = 1; ex_rd = 7;
    #1;
    checks++;
    if (ctrl !== 6'b110100) begin
      errors++;
      $display("FAIL jalr_lu_ctrl: got %b want 110100", ctrl);
    end
    @(posedge CLK); #1;
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL jalr_lu_state: got %0d want 1", state);
    end
    // Load moved to MEM, bubble in EX
    @(negedge CLK);
    set_idle(); id_valid = 1; id_is_jalr = 1; id_rs1 = 7; mem_load = 1; mem_rd = 7;
    #1;
    checks++;
    if (ctrl !== 6'b110100) begin
      errors++;
      $display("FAIL jalr_jm_ctrl: got %b want 110100", ctrl);
    end
    @(posedge CLK); #1;
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL jalr_jm_state: got %0d want 2", state);
    end
    @(negedge CLK);
    set_idle(); id_valid = 1; id_is_jalr = 1; id_rs1 = 7;
    #1;
    checks++;
    if (ctrl !== 6'b000000) begin
      errors++;
      $display("FAIL jalr_release: got %b want 000000", ctrl);
    end
    @(posedge CLK); #1;
    checks++;
    if (state !== 3'd0 || stall_cycles !== 16'd2) begin
      errors++;
      $display("FAIL jalr_after: got state=%0d cnt=%0d want 0 2", state, stall_cycles);
    end
  endtask

  task automatic test_branch_in_stall();
    do_reset();
    drive_lu();
    @(posedge CLK); #1;
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL br_enter_lu: got %0d want 1", state);
    end
    @(negedge CLK);
    drive_lu(); br_taken = 1;
    #1;
    checks++;
    if (ctrl !== 6'b000111) begin
      errors++;
      $display("FAIL br_in_lu_ctrl: got %b want 000111", ctrl);
    end
    @(posedge CLK); #1;
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL br_flush_state: got %0d want 3", state);
    end
    @(negedge CLK);
    set_idle();
    #1;
    checks++;
    if (ctrl !== 6'b000001) begin
      errors++;
      $display("FAIL br_flush_ctrl: got %b want 000001", ctrl);
    end
    @(posedge CLK); #1;
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL br_back_run: got %0d want 0", state);
    end
    // Taken branch, then memory back-pressure while in FLUSH
    @(negedge CLK);
    set_idle(); br_taken = 1;
    @(negedge CLK);
    set_idle(); mem_busy = 1;
    #1;
    checks++;
    if (ctrl !== 6'b111001 || state !== 3'd3) begin
      errors++;
      $display("FAIL flush_busy_ctrl: got %b state=%0d want 111001 state=3", ctrl, state);
    end
    @(posedge CLK); #1;
    checks++;
    if (state !== 3'd4) begin
      errors++;
      $display("FAIL flush_busy_state: got %0d want 4", state);
    end
    @(negedge CLK);
    set_idle();
    @(posedge CLK); #1;
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL flush_busy_exit: got %0d want 0", state);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      set_idle(); mem_busy = 1; br_taken = (k == 5);
      #1;
      checks++;
      if (ctrl !== 6'b111000) begin
        errors++;
        $display("FAIL mw_ctrl[%0d]: got %b want 111000", k, ctrl);
      end
      @(posedge CLK); #1;
      checks++;
      if (state !== 3'd4 || mem_timeout !== (k >= 8)) begin
        errors++;
        $display("FAIL mw_state[%0d]: got state=%0d to=%b want 4 %b",
                 k, state, mem_timeout, (k >= 8));
      end
    end
    @(negedge CLK);
    set_idle();
    #1;
    checks++;
    if (ctrl !== 6'b000000) begin
      errors++;
      $display("FAIL mw_drop: got %b want 000000", ctrl);
    end
    @(posedge CLK); #1;
    checks++;
    if (state !== 3'd0 || stall_cycles !== 16'd10 || mem_timeout !== 1'b1) begin
      errors++;
      $display("FAIL mw_after: got state=%0d cnt=%0d to=%b want 0 10 1",
               state, stall_cycles, mem_timeout);
    end
    // Fresh short run must not re-time-out from a stale count; timeout stays sticky
    @(negedge CLK);
    set_idle(); mem_busy = 1;
    @(posedge CLK); #1;
    checks++;
    if (mem_timeout !== 1'b1 || state !== 3'd4) begin
      errors++;
      $display("FAIL mw_sticky: got to=%b state=%0d want 1 4", mem_timeout, state);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 9; k++) begin
      @(negedge CLK);
      set_idle(); mem_busy = 1;
    end
    @(posedge CLK); #1;
    checks++;
    if (state !== 3'd4 || mem_timeout !== 1'b1 || stall_cycles !== 16'd9) begin
      errors++;
      $display("FAIL ar_pre: got state=%0d to=%b cnt=%0d want 4 1 9",
               state, mem_timeout, stall_cycles);
    end
    #2;
    reset = 0;
    #1;
    checks++;
    if (state !== 3'd0 || stall_cycles !== 16'd0 || mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL ar_now: got state=%0d cnt=%0d to=%b want 0 0 0",
               state, stall_cycles, mem_timeout);
    end
    set_idle();
    @(negedge CLK);
    reset = 1;
    // Wait counter must have cleared: 7 busy cycles stay below the limit
    for (int k = 0; k < 7; k++) begin
      @(negedge CLK);
      set_idle(); mem_busy = 1;
    end
    @(posedge CLK); #1;
    checks++;
    if (mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL ar_wait_clear: got to=%b want 0", mem_timeout);
    end
    @(negedge CLK);
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_load_use();
    test_filter();
    test_jalr();
    test_branch_in_stall();
    test_mem_wait();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
